// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - opcode/condition encodings, NZCV bit indices and branch condition helper
package exec_pkg;

  typedef enum logic [3:0] {
    OP_MOV = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_ORR = 4'd4,
    OP_EOR = 4'd5,
    OP_MUL = 4'd6,
    OP_CMP = 4'd7,
    OP_LDR = 4'd8,
    OP_STR = 4'd9,
    OP_B   = 4'd10
  } opcode_e;

  typedef enum logic [2:0] {
    COND_AL = 3'd0,
    COND_EQ = 3'd1,
    COND_NE = 3'd2,
    COND_LT = 3'd3,
    COND_GE = 3'd4,
    COND_CS = 3'd5,
    COND_CC = 3'd6,
    COND_MI = 3'd7
  } cond_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic cond_true(input logic [3:0] flags, input logic [2:0] cond);
    logic res;
    case (cond_e'(cond))
      COND_AL: res = 1'b1;
      COND_EQ: res = flags[FLAG_Z];
      COND_NE: res = ~flags[FLAG_Z];
      COND_LT: res = flags[FLAG_N] ^ flags[FLAG_V];
      COND_GE: res = ~(flags[FLAG_N] ^ flags[FLAG_V]);
      COND_CS: res = flags[FLAG_C];
      COND_CC: res = ~flags[FLAG_C];
      COND_MI: res = flags[FLAG_N];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/exec_mul_seq.sv
// rtl/exec_mul_seq.sv - iterative shift-add multiplier, one multiplier bit per cycle
module exec_mul_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] accNext;
  logic [CNT_W-1:0]  cnt;
  logic              busyQ;

  // Partial product for the current multiplier bit; on the last cycle this is the final product.
  always_comb begin
    accNext = mplier[0] ? (acc + mcand) : acc;
  end

  // Operand shift registers, accumulator and remaining-bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busyQ  <= 1'b0;
    end else if (start) begin
      mcand  <= opA;
      mplier <= opB;
      acc    <= '0;
      cnt    <= CNT_W'(DATA_W);
      busyQ  <= 1'b1;
    end else if (busyQ) begin
      acc    <= accNext;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busyQ <= 1'b0;
      end
    end
  end

  // done is combinational so the consumer can capture product on the final edge.
  assign busy    = busyQ;
  assign done    = busyQ && (cnt == CNT_W'(1));
  assign product = accNext;

endmodule

// File: rtl/exec_stage_pipe.sv
// rtl/exec_stage_pipe.sv - handshaked execute stage with registered result, NZCV flags and branch evaluation
module exec_stage_pipe
  import exec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic              use_imm,
  input  logic              set_flags,
  input  logic [2:0]        cond,
  input  logic [IMM_W-1:0]  imm,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [DATA_W-1:0] src_d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              br_taken,
  output logic [IMM_W-1:0]  br_offset,
  output logic [3:0]        flags
);

  localparam int MSB = DATA_W - 1;

  state_e state, stateNext;

  logic accept, mulStart, loadAlu, load;
  logic mulBusy, mulDone;
  logic [DATA_W-1:0] mulProduct;
  logic [REG_AW-1:0] mulDest;
  logic              mulSetFlags;

  logic [DATA_W-1:0] immExt, bOp, aluRes, addr;
  logic [DATA_W:0]   sumW, diffW;
  logic              aluC, aluV, updNZ, updCV;
  logic              aWbEn, aMemRd, aMemWr, aBrTaken;
  logic [REG_AW-1:0] aWbReg;
  logic [DATA_W-1:0] aMemAddr, aMemWdata;
  logic [IMM_W-1:0]  aBrOffset;
  logic [3:0]        aFlags;

  logic              nWbEn, nMemRd, nMemWr, nBrTaken;
  logic [REG_AW-1:0] nWbReg;
  logic [DATA_W-1:0] nWbData, nMemAddr, nMemWdata;
  logic [IMM_W-1:0]  nBrOffset;
  logic [3:0]        nFlags;

  assign in_ready = rst_n & (state == IDLE) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign mulStart = accept & (op == OP_MUL);
  assign loadAlu  = accept & (op != OP_MUL);
  assign load     = loadAlu | mulDone;

  exec_mul_seq #(.DATA_W(DATA_W)) uMul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mulStart),
    .opA     (src_a),
    .opB     (bOp),
    .busy    (mulBusy),
    .done    (mulDone),
    .product (mulProduct)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state: leave IDLE on a MUL accept, return when the multiplier finishes.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (mulStart) stateNext = MUL;
      MUL:     if (mulDone || !mulBusy) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Writeback target and flag enable of the in-flight multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mulDest     <= '0;
      mulSetFlags <= 1'b0;
    end else if (mulStart) begin
      mulDest     <= dest_reg;
      mulSetFlags <= set_flags;
    end
  end

  // Single-cycle datapath: ALU, flag generation, address generation and branch evaluation.
  always_comb begin
    immExt    = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    bOp       = use_imm ? immExt : src_b;
    sumW      = {1'b0, src_a} + {1'b0, bOp};
    diffW     = {1'b0, src_a} - {1'b0, bOp};
    addr      = src_a + immExt;
    aluRes    = '0;
    aluC      = flags[FLAG_C];
    aluV      = flags[FLAG_V];
    updNZ     = 1'b0;
    updCV     = 1'b0;
    aWbEn     = 1'b0;
    aWbReg    = '0;
    aMemRd    = 1'b0;
    aMemWr    = 1'b0;
    aMemAddr  = '0;
    aMemWdata = '0;
    aBrTaken  = 1'b0;
    aBrOffset = '0;
    case (op)
      OP_MOV: begin aluRes = bOp;         updNZ = 1'b1; aWbEn = 1'b1; end
      OP_AND: begin aluRes = src_a & bOp; updNZ = 1'b1; aWbEn = 1'b1; end
      OP_ORR: begin aluRes = src_a | bOp; updNZ = 1'b1; aWbEn = 1'b1; end
      OP_EOR: begin aluRes = src_a ^ bOp; updNZ = 1'b1; aWbEn = 1'b1; end
      OP_ADD: begin
        aluRes = sumW[MSB:0];
        aluC   = sumW[DATA_W];
        aluV   = ~(src_a[MSB] ^ bOp[MSB]) & (src_a[MSB] ^ aluRes[MSB]);
        updNZ  = 1'b1;
        updCV  = 1'b1;
        aWbEn  = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        aluRes = diffW[MSB:0];
        aluC   = ~diffW[DATA_W];
        aluV   = (src_a[MSB] ^ bOp[MSB]) & (src_a[MSB] ^ aluRes[MSB]);
        updNZ  = 1'b1;
        updCV  = 1'b1;
        aWbEn  = (op == OP_SUB);
      end
      OP_LDR: begin aMemRd = 1'b1; aMemAddr = addr; aWbReg = dest_reg; end
      OP_STR: begin aMemWr = 1'b1; aMemAddr = addr; aMemWdata = src_d; end
      OP_B:   begin aBrTaken = cond_true(flags, cond); aBrOffset = imm; end
      default: ;
    endcase
    if (aWbEn) aWbReg = dest_reg;
    aFlags = flags;
    if (set_flags || (op == OP_CMP)) begin
      if (updNZ) begin
        aFlags[FLAG_N] = aluRes[MSB];
        aFlags[FLAG_Z] = (aluRes == '0);
      end
      if (updCV) begin
        aFlags[FLAG_C] = aluC;
        aFlags[FLAG_V] = aluV;
      end
    end
  end

  // Result-register source: the finishing multiply, otherwise the single-cycle datapath.
  always_comb begin
    nWbEn     = aWbEn;
    nWbReg    = aWbReg;
    nWbData   = aluRes;
    nMemRd    = aMemRd;
    nMemWr    = aMemWr;
    nMemAddr  = aMemAddr;
    nMemWdata = aMemWdata;
    nBrTaken  = aBrTaken;
    nBrOffset = aBrOffset;
    nFlags    = aFlags;
    if (mulDone) begin
      nWbEn     = 1'b1;
      nWbReg    = mulDest;
      nWbData   = mulProduct;
      nMemRd    = 1'b0;
      nMemWr    = 1'b0;
      nMemAddr  = '0;
      nMemWdata = '0;
      nBrTaken  = 1'b0;
      nBrOffset = '0;
      nFlags    = flags;
      if (mulSetFlags) begin
        nFlags[FLAG_N] = mulProduct[MSB];
        nFlags[FLAG_Z] = (mulProduct == '0);
      end
    end
  end

  // Result and flag registers: load on a completing op, hold while stalled, drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      wb_en     <= 1'b0;
      wb_reg    <= '0;
      wb_data   <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      br_taken  <= 1'b0;
      br_offset <= '0;
      flags     <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      wb_en     <= nWbEn;
      wb_reg    <= nWbReg;
      wb_data   <= nWbData;
      mem_rd    <= nMemRd;
      mem_wr    <= nMemWr;
      mem_addr  <= nMemAddr;
      mem_wdata <= nMemWdata;
      br_taken  <= nBrTaken;
      br_offset <= nBrOffset;
      flags     <= nFlags;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_stage_pipe.sv
// tb/tb_exec_stage_pipe.sv - directed self-checking bench for exec_stage_pipe
module tb_exec_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  op;
  logic        use_imm, set_flags;
  logic [2:0]  cond;
  logic [15:0] imm;
  logic [3:0]  dest_reg;
  logic [31:0] src_a, src_b, src_d;
  logic        out_valid, out_ready;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic        br_taken;
  logic [15:0] br_offset;
  logic [3:0]  flags;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  exec_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .use_imm(use_imm), .set_flags(set_flags), .cond(cond), .imm(imm), .dest_reg(dest_reg),
    .src_a(src_a), .src_b(src_b), .src_d(src_d), .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .br_taken(br_taken), .br_offset(br_offset),
    .flags(flags)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic ui, input logic sf, input logic [2:0] c,
                       input logic [15:0] im, input logic [3:0] dr,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
    op = o; use_imm = ui; set_flags = sf; cond = c; imm = im; dest_reg = dr;
    src_a = a; src_b = b; src_d = d; in_valid = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(4'd0, 1'b0, 1'b0, 3'd0, 16'h0, 4'd0, 32'h0, 32'h0, 32'h0);
    in_valid = 1'b0;
    step; step;
    testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    testsRun++; if (flags !== 4'h0) begin testsFailed++; $display("FAIL rst_flags: got %b want 0000", flags); end
    testsRun++; if (wb_data !== 32'h0 || wb_en !== 1'b0) begin testsFailed++; $display("FAIL rst_wb: got %h/%b want 0/0", wb_data, wb_en); end
    testsRun++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || br_taken !== 1'b0) begin testsFailed++; $display("FAIL rst_effects: got %b%b%b want 000", mem_rd, mem_wr, br_taken); end
    rst_n = 1'b1;
    #1;
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add_overflow;
    drive(4'd1, 1'b1, 1'b1, 3'd0, 16'h0001, 4'd3, 32'h7FFFFFFF, 32'h0, 32'h0);
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
    step;
    in_valid = 1'b0;
    testsRun++; if (out_valid !== 1'b1) begin testsFailed++; $display("FAIL add_latency: got %b want 1", out_valid); end
    testsRun++; if (wb_data !== 32'h80000000) begin testsFailed++; $display("FAIL add_wb_data: got %h want 80000000", wb_data); end
    testsRun++; if (flags !== 4'b1001) begin testsFailed++; $display("FAIL add_flags: got %b want 1001", flags); end
    testsRun++; if (wb_en !== 1'b1 || wb_reg !== 4'd3) begin testsFailed++; $display("FAIL add_wb_target: got %b/%0d want 1/3", wb_en, wb_reg); end
    step;
    testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("FAIL add_consumed: got %b want 0", out_valid); end
  endtask

  task automatic test_sub_branch;
    drive(4'd2, 1'b0, 1'b1, 3'd0, 16'h0, 4'd2, 32'd5, 32'd5, 32'h0);
    step;
    testsRun++; if (wb_data !== 32'h0) begin testsFailed++; $display("FAIL sub_wb_data: got %h want 0", wb_data); end
    testsRun++; if (flags !== 4'b0110) begin testsFailed++; $display("FAIL sub_flags: got %b want 0110", flags); end
    drive(4'd10, 1'b0, 1'b0, 3'd1, 16'hFFFC, 4'd0, 32'h0, 32'h0, 32'h0);
    step;
    testsRun++; if (br_taken !== 1'b1) begin testsFailed++; $display("FAIL beq_taken: got %b want 1", br_taken); end
    testsRun++; if (br_offset !== 16'hFFFC) begin testsFailed++; $display("FAIL beq_offset: got %h want fffc", br_offset); end
    testsRun++; if (wb_en !== 1'b0 || out_valid !== 1'b1) begin testsFailed++; $display("FAIL beq_wb_valid: got %b/%b want 0/1", wb_en, out_valid); end
    drive(4'd10, 1'b0, 1'b0, 3'd3, 16'h0010, 4'd0, 32'h0, 32'h0, 32'h0);
    step;
    testsRun++; if (br_taken !== 1'b0) begin testsFailed++; $display("FAIL blt_taken: got %b want 0", br_taken); end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_back_to_back;
    drive(4'd4, 1'b0, 1'b0, 3'd0, 16'h0, 4'd1, 32'h000000F0, 32'h0000000F, 32'h0);
    step;
    testsRun++; if (wb_data !== 32'h000000FF || in_ready !== 1'b1) begin testsFailed++; $display("FAIL orr_result: got %h/%b want 000000ff/1", wb_data, in_ready); end
    drive(4'd5, 1'b1, 1'b1, 3'd0, 16'hFFFF, 4'd1, 32'h000000FF, 32'h0, 32'h0);
    step;
    testsRun++; if (wb_data !== 32'hFFFFFF00) begin testsFailed++; $display("FAIL eor_wb_data: got %h want ffffff00", wb_data); end
    testsRun++; if (flags !== 4'b1010) begin testsFailed++; $display("FAIL eor_flags: got %b want 1010", flags); end
    drive(4'd3, 1'b0, 1'b1, 3'd0, 16'h0, 4'd1, 32'h0000000F, 32'h000000F0, 32'h0);
    step;
    testsRun++; if (wb_data !== 32'h0 || flags !== 4'b0110) begin testsFailed++; $display("FAIL and_result: got %h/%b want 0/0110", wb_data, flags); end
    drive(4'd0, 1'b1, 1'b0, 3'd0, 16'h8000, 4'd8, 32'h0, 32'h0, 32'h0);
    step;
    testsRun++; if (wb_data !== 32'hFFFF8000 || flags !== 4'b0110 || wb_reg !== 4'd8) begin testsFailed++; $display("FAIL mov_imm: got %h/%b/%0d want ffff8000/0110/8", wb_data, flags, wb_reg); end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_mem;
    drive(4'd9, 1'b0, 1'b0, 3'd0, 16'hFFF8, 4'd0, 32'h00001000, 32'h0, 32'hDEADBEEF);
    step;
    testsRun++; if (mem_addr !== 32'h00000FF8) begin testsFailed++; $display("FAIL str_addr: got %h want 00000ff8", mem_addr); end
    testsRun++; if (mem_wdata !== 32'hDEADBEEF) begin testsFailed++; $display("FAIL str_wdata: got %h want deadbeef", mem_wdata); end
    testsRun++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || wb_en !== 1'b0) begin testsFailed++; $display("FAIL str_ctrl: got wr%b rd%b wb%b want 1 0 0", mem_wr, mem_rd, wb_en); end
    drive(4'd8, 1'b0, 1'b0, 3'd0, 16'h0010, 4'd7, 32'h00002000, 32'h0, 32'h0);
    step;
    testsRun++; if (mem_addr !== 32'h00002010 || mem_rd !== 1'b1 || mem_wr !== 1'b0) begin testsFailed++; $display("FAIL ldr_req: got %h rd%b wr%b want 00002010 1 0", mem_addr, mem_rd, mem_wr); end
    testsRun++; if (wb_en !== 1'b0 || wb_reg !== 4'd7) begin testsFailed++; $display("FAIL ldr_wb: got %b/%0d want 0/7", wb_en, wb_reg); end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_mul;
    int lowCycles;
    logic sawEarly;
    drive(4'd6, 1'b0, 1'b0, 3'd0, 16'h0, 4'd5, 32'h0000FFFF, 32'h00010001, 32'h0);
    step;
    in_valid = 1'b0;
    lowCycles = 0;
    sawEarly = 1'b0;
    while (in_ready !== 1'b1 && lowCycles < 100) begin
      lowCycles++;
      if (out_valid === 1'b1) sawEarly = 1'b1;
      step;
    end
    testsRun++; if (lowCycles != 32) begin testsFailed++; $display("FAIL mul_busy_cycles: got %0d want 32", lowCycles); end
    testsRun++; if (sawEarly !== 1'b0) begin testsFailed++; $display("FAIL mul_early_valid: got %b want 0", sawEarly); end
    testsRun++; if (out_valid !== 1'b1) begin testsFailed++; $display("FAIL mul_valid_edge33: got %b want 1", out_valid); end
    testsRun++; if (wb_data !== 32'hFFFFFFFF) begin testsFailed++; $display("FAIL mul_wb_data: got %h want ffffffff", wb_data); end
    testsRun++; if (wb_en !== 1'b1 || wb_reg !== 4'd5 || flags !== 4'b0110) begin testsFailed++; $display("FAIL mul_wb_flags: got %b/%0d/%b want 1/5/0110", wb_en, wb_reg, flags); end
    step;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(4'd1, 1'b0, 1'b1, 3'd0, 16'h0, 4'd4, 32'd1, 32'd2, 32'h0);
    step;
    drive(4'd2, 1'b1, 1'b0, 3'd0, 16'h0003, 4'd6, 32'd10, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      testsRun++; if (out_valid !== 1'b1 || wb_data !== 32'd3 || wb_reg !== 4'd4) begin testsFailed++; $display("FAIL hold_result[%0d]: got %b/%h/%0d want 1/3/4", i, out_valid, wb_data, wb_reg); end
      testsRun++; if (flags !== 4'b0000) begin testsFailed++; $display("FAIL hold_flags[%0d]: got %b want 0000", i, flags); end
      testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
      if (i < 2) step;
    end
    step;
    out_ready = 1'b1;
    #1;
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    step;
    in_valid = 1'b0;
    testsRun++; if (out_valid !== 1'b1 || wb_data !== 32'd7 || wb_reg !== 4'd6) begin testsFailed++; $display("FAIL release_next: got %b/%h/%0d want 1/7/6", out_valid, wb_data, wb_reg); end
    testsRun++; if (flags !== 4'b0000) begin testsFailed++; $display("FAIL release_flags: got %b want 0000", flags); end
    step;
  endtask

  task automatic test_reset_mid_mul;
    logic sawValid;
    drive(4'd7, 1'b0, 1'b0, 3'd0, 16'h0, 4'd9, 32'd1, 32'd2, 32'h0);
    step;
    testsRun++; if (flags !== 4'b1000 || wb_en !== 1'b0) begin testsFailed++; $display("FAIL cmp_flags: got %b/%b want 1000/0", flags, wb_en); end
    drive(4'd6, 1'b0, 1'b1, 3'd0, 16'h0, 4'd2, 32'd3, 32'd5, 32'h0);
    step;
    in_valid = 1'b0;
    repeat (9) step;
    rst_n = 1'b0;
    #1;
    testsRun++; if (flags !== 4'h0) begin testsFailed++; $display("FAIL midrst_flags: got %b want 0000", flags); end
    testsRun++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin testsFailed++; $display("FAIL midrst_handshake: got %b/%b want 0/0", out_valid, in_ready); end
    testsRun++; if (wb_data !== 32'h0 || wb_en !== 1'b0 || wb_reg !== 4'd0) begin testsFailed++; $display("FAIL midrst_wb: got %h/%b/%0d want 0/0/0", wb_data, wb_en, wb_reg); end
    step; step;
    rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (40) begin
      step;
      if (out_valid !== 1'b0) sawValid = 1'b1;
    end
    testsRun++; if (sawValid !== 1'b0 || flags !== 4'h0) begin testsFailed++; $display("FAIL midrst_no_result: got %b/%b want 0/0000", sawValid, flags); end
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    drive(4'd1, 1'b1, 1'b1, 3'd0, 16'h0003, 4'd1, 32'd2, 32'h0, 32'h0);
    step;
    in_valid = 1'b0;
    testsRun++; if (out_valid !== 1'b1 || wb_data !== 32'd5) begin testsFailed++; $display("FAIL midrst_accept: got %b/%h want 1/5", out_valid, wb_data); end
    step;
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_sub_branch;
    test_back_to_back;
    test_mem;
    test_mul;
    test_backpressure;
    test_reset_mid_mul;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exec_stage_pipe.md
# exec_stage_pipe

Parametrised, handshaked execute stage for the SCC core. It replaces the purely combinational execute with a registered result stage, a registered NZCV flag file and a full condition-code branch evaluator. It also adds an iterative multi-cycle multiplier. It sits between decode/register-read and the memory/writeback stage.

## Interface
- DATA_W, 32, datapath and register width
- IMM_W, 16, immediate width; sign-extended to DATA_W
- REG_AW, 4, register-address width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decoded op presented
- in_ready  out  1  stage accepts the op this cycle
- op  in  4  opcode: 0 MOV, 1 ADD, 2 SUB, 3 AND, 4 ORR, 5 EOR, 6 MUL, 7 CMP, 8 LDR, 9 STR, 10 B; 11–15 NOP
- use_imm  in  1  operand B is sext(imm) instead of src_b
- set_flags  in  1  update NZCV; CMP always updates
- cond  in  3  branch condition: 0 AL, 1 EQ, 2 NE, 3 LT, 4 GE, 5 CS, 6 CC, 7 MI
- imm  in  IMM_W  signed immediate or branch offset
- dest_reg  in  REG_AW  destination register
- src_a, src_b, src_d  in  DATA_W  register read data: base/first operand, second operand, store data
- out_valid  out  1  result register holds a valid op
- out_ready  in  1  downstream consumes the result
- wb_en  out  1  write wb_data to wb_reg
- wb_reg  out  REG_AW  writeback register
- wb_data  out  DATA_W  ALU result
- mem_rd, mem_wr  out  1  load / store request
- mem_addr, mem_wdata  out  DATA_W  effective address, store data
- br_taken  out  1  branch taken
- br_offset  out  IMM_W  branch offset (imm passthrough)
- flags  out  4  registered NZCV, bit 3 = N

## Operation
- B operand = use_imm ? sext(imm) : src_b. All arithmetic wraps mod 2^DATA_W.
- ADD: r = a+b; C = carry out; V = ~(a^b)[msb] & (a^r)[msb].
- SUB and CMP: r = a−b; C = no-borrow (a ≥ b unsigned); V = (a^b)[msb] & (a^r)[msb]. CMP writes only flags (wb_en = 0).
- AND/ORR/EOR/MUL: update N and Z only; C and V hold. MUL keeps the low DATA_W bits.
- MOV: wb_data = B.
- N = r[msb]. Z = (r == 0). Flags change only when set_flags is 1 or op is CMP.
- LDR: mem_rd = 1, mem_addr = a + sext(imm), wb_reg = dest_reg, wb_en = 0; the memory stage writes back.
- STR: mem_wr = 1, same address, mem_wdata = src_d, wb_en = 0.
- B: br_taken = cond true against the current flags register (LT: N≠V; GE: N==V; CS: C; CC: ~C; MI: N). br_offset = imm. No writeback.
- NOP: out_valid asserted with all effect outputs 0.
- FSM states: IDLE, MUL.
  - IDLE: accept when in_valid & in_ready. Non-MUL ops load the result register and flags on the accept edge. MUL latches its operands and enters MUL.
  - MUL: shift-add, one multiplier bit per cycle, DATA_W cycles. On the last cycle it loads the result register (and flags if enabled), then returns to IDLE.

## Timing
- in_ready = (state == IDLE) & (~out_valid | out_ready).
- Single-cycle ops: out_valid rises on the edge after acceptance (latency 1). Back-to-back at one op per cycle when out_ready = 1.
- MUL: in_ready is low for DATA_W cycles. out_valid rises DATA_W+1 edges after acceptance.
- Hold: while out_valid & ~out_ready, every output and the flags register stay stable.
- out_valid falls after the consuming edge unless a new op loads on that same edge.
- Flag ordering: flags update on the same edge as the producing result loads. A dependent branch accepted on the next cycle sees the new flags, so no hazard logic is needed.
- Reset: every output is 0 (in_ready is also 0 while rst_n is low), flags = 0, state = IDLE.
- Reset asserted mid-MUL aborts the multiply; no result or flag update is ever produced.

## Structure
- Package exec_pkg holds the opcode and cond enums, the NZCV bit-index constants, and a cond_true(flags, cond) function.
- One sub-module, exec_mul_seq: iterative DATA_W-cycle multiplier with start/busy/done handshake and operand and result ports. It is instantiated once.

## Test plan
- ADD imm, a = 0x7FFFFFFF, imm = 1, set_flags → wb_data = 0x80000000, NZCV = 1001, out_valid one cycle after accept.
- SUB reg a = 5, b = 5, set_flags, then B EQ imm = −4 → wb_data = 0, NZCV = 0110; branch: br_taken = 1, br_offset = 0xFFFC.
- MUL a = 0xFFFF, b = 0x10001 → wb_data = 0xFFFFFFFF; in_ready low exactly 32 cycles; out_valid on edge 33.
- ADD completes with out_ready = 0 for 3 cycles → outputs and flags frozen, in_ready = 0; next op accepted on the cycle out_ready returns to 1.
- STR a = 0x1000, imm = −8, src_d = 0xDEADBEEF → mem_addr = 0x00000FF8, mem_wdata = 0xDEADBEEF, mem_wr = 1, wb_en = 0.
- rst_n low at MUL cycle 10 → all outputs and flags 0, no out_valid pulse; after release in_ready = 1 and IDLE accepts.
